// File: rtl/fifo_stream_reader.sv
// Pops a FIFO whose read data is registered, parks fetched words in a 2-entry
// in-order buffer and offers them on a valid/ready stream, counting accepted words.
module fifo_stream_reader #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic          in_clk,
  input  logic          in_rst_n,
  input  logic          in_en,
  input  logic          in_fifo_empty,
  input  logic [W-1:0]  in_fifo_data,
  output logic          o_fifo_r_en,
  input  logic          in_ready,
  output logic          o_valid,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_busy
);

  logic [1:0]    occ_q, occ_d, occ_after;
  logic          pend_q, pend_d;
  logic [W-1:0]  head_q, head_d;
  logic [W-1:0]  tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_out;
  logic [2:0]    load;

  always_comb begin
    pop_out   = (occ_q != 2'd0) & in_ready;
    load      = {1'b0, occ_q} + {2'b00, pend_q};
    // (occ + pend - pop_out) < 2, rearranged so the compare never goes negative
    o_fifo_r_en = in_rst_n & in_en & ~in_fifo_empty
                & (load < (3'd2 + {2'b00, pop_out}));
    pend_d    = o_fifo_r_en;
    occ_after = occ_q - {1'b0, pop_out};
    head_d    = head_q;
    tail_d    = tail_q;
    if (pop_out) begin
      head_d = tail_q;
    end
    if (pend_q) begin
      if (occ_after == 2'd0) begin
        head_d = in_fifo_data;
      end else begin
        tail_d = in_fifo_data;
      end
    end
    occ_d   = occ_after + {1'b0, pend_q};
    count_d = count_q + CW'(pop_out);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      occ_q   <= 2'd0;
      pend_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      occ_q   <= occ_d;
      pend_q  <= pend_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign o_valid = (occ_q != 2'd0);
  assign o_data  = head_q;
  assign o_count = count_q;
  assign o_busy  = (occ_q != 2'd0) | pend_q;

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter W, default 32, data word width.
REQ-002 SHALL have parameter CW, default 16, width of delivered-word counter.
REQ-003 SHALL have port in_clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port in_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_en  input  1  enable issuing new FIFO reads; 0 = stop popping, drain already-fetched words.
REQ-006 SHALL have port in_fifo_empty  input  1  FIFO empty flag.
REQ-007 SHALL have port in_fifo_data  input  W  FIFO read data, registered in FIFO, valid the cycle after a pop.
REQ-008 SHALL have port o_fifo_r_en  output  1  FIFO read enable (pop request).
REQ-009 SHALL have port in_ready  input  1  downstream ready.
REQ-010 SHALL have port o_valid  output  1  downstream data valid.
REQ-011 SHALL have port o_data  output  W  downstream data.
REQ-012 SHALL have port o_count  output  CW  number of words accepted downstream since reset.
REQ-013 SHALL have port o_busy  output  1  1 when any word is in flight or buffered.

Function
REQ-014 SHALL hold a 2-entry in-order output buffer (occupancy occ 0..2) and a 1-bit pending flag pend marking a pop issued last cycle.
REQ-015 SHALL define pop_out = o_valid & in_ready; a word is transferred downstream only on pop_out.
REQ-016 SHALL drive o_fifo_r_en combinationally = in_en & ~in_fifo_empty & ((occ + pend - pop_out) < 2).
REQ-017 SHALL never assert o_fifo_r_en while in_fifo_empty = 1.
REQ-018 SHALL set pend on the next edge to the value of o_fifo_r_en.
REQ-019 SHALL, when pend = 1, write in_fifo_data into the buffer tail on that edge; occ next = occ + pend - pop_out.
REQ-020 SHALL maintain invariant occ + pend <= 2; write into a full buffer SHALL be impossible by construction.
REQ-021 SHALL drive o_valid = (occ != 0) and o_data = buffer head; both come from registers.
REQ-022 SHALL keep o_data and o_valid stable while o_valid = 1 and in_ready = 0.
REQ-023 SHALL support simultaneous buffer write (pend) and pop_out in one cycle, preserving order.
REQ-024 SHALL deliver words in exact FIFO pop order, no drops, no duplicates.
REQ-025 SHALL have latency 2 cycles: o_fifo_r_en high in cycle t -> word visible on o_data with o_valid in cycle t+2 when buffer was empty.
REQ-026 SHALL sustain 1 word/cycle when FIFO non-empty, in_en = 1, in_ready held 1.
REQ-027 SHALL, when in_en drops, stop new pops next evaluation but still capture a pending word and keep offering buffered words.
REQ-028 SHALL increment o_count by 1 on every pop_out, wrapping modulo 2^CW.
REQ-029 SHALL drive o_busy = (occ != 0) | pend.

Reset
REQ-030 SHALL, while in_rst_n = 0, asynchronously force occ = 0, pend = 0, o_count = 0, o_valid = 0, o_busy = 0, o_fifo_r_en = 0.
REQ-031 SHALL clear o_data to 0 on reset.
REQ-032 SHALL discard any pending or buffered words on reset mid-operation; the FIFO pointer advance for a pending pop is not recovered.
REQ-033 SHALL resume normal operation on the first rising edge after in_rst_n deasserts.

Verification
REQ-034 Single word: FIFO holds 0xA5A5A5A5, in_en = 1, in_ready = 1 -> r_en cycle t, o_valid with o_data = 0xA5A5A5A5 in t+2 only, o_count = 1.
REQ-035 Stream: 8 words 1..8, in_ready = 1 -> r_en high 8 consecutive cycles, o_valid high 8 consecutive cycles, data 1..8 in order, o_count = 8.
REQ-036 Back-pressure: 8 words, in_ready = 0 for 5 cycles then 1 -> at most 2 pops issued during stall, o_data held at word 1, then 1..8 in order, no loss.
REQ-037 Alternating in_ready 1/0 with FIFO kept non-empty -> occ + pend never exceeds 2, output order intact, r_en never asserted while empty.
REQ-038 in_en dropped the cycle after a pop -> pending word still appears on o_valid, no further r_en, o_busy falls to 0 after it is accepted.
REQ-039 in_rst_n pulled low asynchronously with 2 words buffered -> o_valid, o_busy, o_fifo_r_en, o_count go 0 immediately, without a clock edge.
